// File: rtl/jtag_pkg.sv
// TAP state encoding (IEEE 1149.1 values) and the TMS-driven next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        P_DR   = 4'h3, EX2_DR = 4'h0, UP_DR  = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        P_IR   = 4'hB, EX2_IR = 4'h8, UP_IR  = 4'hD
    } tap_state_e;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UP_DR  : P_DR;
            P_DR:    tap_next = tms ? EX2_DR : P_DR;
            EX2_DR:  tap_next = tms ? UP_DR  : SH_DR;
            UP_DR:   tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UP_IR  : P_IR;
            P_IR:    tap_next = tms ? EX2_IR : P_IR;
            EX2_IR:  tap_next = tms ? UP_IR  : SH_IR;
            UP_IR:   tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, next-state logic and IR/DR strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output logic [3:0] state_o,
    output logic [3:0] state_next_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = tap_next(state_q, tms_i);
    end

    always_comb begin
        state_o      = state_q;
        state_next_o = state_d;
        capture_dr_o = (state_q == CAP_DR);
        shift_dr_o   = (state_q == SH_DR);
        update_dr_o  = (state_q == UP_DR);
        capture_ir_o = (state_q == CAP_IR);
        shift_ir_o   = (state_q == SH_IR);
        update_ir_o  = (state_q == UP_IR);
    end

endmodule

// File: rtl/jtag_tap_gen.sv
// TAP top: IR, opcode decode, IDCODE/BYPASS registers and falling-edge TDO launch.
module jtag_tap_gen
    import jtag_pkg::*;
#(
    parameter int                               IR_LENGTH    = 5,
    parameter int                               NUM_CH       = 4,
    parameter logic [31:0]                      IDCODE_VALUE = 32'h10102001,
    parameter logic [IR_LENGTH-1:0]             IDCODE_OP    = 'b00001,
    parameter logic [IR_LENGTH-1:0]             BYPASS_OP    = '1,
    parameter logic [IR_LENGTH-1:0]             IR_CAPTURE   = 'b00101,
    parameter logic [NUM_CH*IR_LENGTH-1:0]      CH_OPCODE    = {5'h0B, 5'h0A, 5'h09, 5'h08}
) (
    input  logic                 tck_i,
    input  logic                 rst_i,
    input  logic                 tms_i,
    input  logic                 td_i,
    output logic                 td_o,
    output logic                 tdo_oe_o,
    output logic [3:0]           tap_state_o,
    output logic [IR_LENGTH-1:0] instr_o,
    output logic                 capture_dr_o,
    output logic                 shift_dr_o,
    output logic                 update_dr_o,
    output logic                 scan_in_o,
    output logic [NUM_CH-1:0]    ch_sel_o,
    input  logic [NUM_CH-1:0]    ch_tdo_i
);

    logic [3:0]           state, state_next;
    logic                 capture_ir, shift_ir, update_ir;
    logic [IR_LENGTH-1:0] ir_q, instr_q;
    logic [31:0]          idcode_q;
    logic                 bypass_q;
    logic                 sel_idcode, found, tdo_d;
    logic [NUM_CH-1:0]    ch_hit, ch_sel;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .rst_i        (rst_i),
        .tms_i        (tms_i),
        .state_o      (state),
        .state_next_o (state_next),
        .capture_dr_o (capture_dr_o),
        .shift_dr_o   (shift_dr_o),
        .update_dr_o  (update_dr_o),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir)
    );

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)           ir_q <= IR_CAPTURE;
        else if (capture_ir) ir_q <= IR_CAPTURE;
        else if (shift_ir)   ir_q <= {td_i, ir_q[IR_LENGTH-1:1]};
    end

    // Forcing on the edge that enters TLR makes the 5-TMS reset take effect on arrival.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)                   instr_q <= IDCODE_OP;
        else if (state_next == TLR)  instr_q <= IDCODE_OP;
        else if (update_ir)          instr_q <= ir_q;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [IR_LENGTH-1:0] OP = CH_OPCODE[i*IR_LENGTH +: IR_LENGTH];
        assign ch_hit[i] = (instr_q == OP) && (OP != IDCODE_OP) && (OP != BYPASS_OP);
    end

    always_comb begin
        ch_sel = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i] && !found) begin
                ch_sel[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign sel_idcode = (instr_q == IDCODE_OP);

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)                       idcode_q <= IDCODE_VALUE;
        else if (capture_dr_o)           idcode_q <= IDCODE_VALUE;
        else if (shift_dr_o && sel_idcode) idcode_q <= {td_i, idcode_q[31:1]};
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)             bypass_q <= 1'b0;
        else if (capture_dr_o) bypass_q <= 1'b0;
        else if (shift_dr_o)   bypass_q <= td_i;
    end

    always_comb begin
        if (shift_ir)        tdo_d = ir_q[0];
        else if (sel_idcode) tdo_d = idcode_q[0];
        else if (|ch_sel)    tdo_d = |(ch_sel & ch_tdo_i);
        else                 tdo_d = bypass_q;
    end

    // Launch on the falling edge so the host sees a stable bit at its next rising edge.
    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            td_o     <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_oe_o <= shift_ir || shift_dr_o;
            if (shift_ir || shift_dr_o) td_o <= tdo_d;
        end
    end

    assign tap_state_o = state;
    assign instr_o     = instr_q;
    assign ch_sel_o    = ch_sel;
    assign scan_in_o   = td_i;

endmodule
